// File: rtl/cpu_mu0_param.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mu0_param
// Description : Parametrised multi-cycle MU0 accumulator CPU with a
//               waitrequest-stalled shared memory bus and a registered OUT
//               port. Optional macro CPU_MU0_PARAM_SATURATE_EN makes ADD/SUB
//               saturate at signed DATA_WIDTH limits instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mu0_param #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  running,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    output logic [DATA_WIDTH-1:0] writedata,
    input  logic [DATA_WIDTH-1:0] readdata,
    input  logic                  waitrequest,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;
    localparam logic [3:0] OP_OUT = 4'd8;

    // HALTED encodes as zero so the power-on state is the halted one.
    typedef enum logic [1:0] {
        HALTED = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0]   acc;
    logic [DATA_WIDTH-1:0]   ir;
    logic [3:0]              opcode;
    logic [ADDR_WIDTH-1:0]   operand;
    logic                    mem_op;
    logic                    is_store;
    logic                    is_sub;
    logic                    exec_done;
    logic [DATA_WIDTH-1:0]   addend;
    logic [DATA_WIDTH-1:0]   sum;
    logic [DATA_WIDTH-1:0]   alu_result;

    assign opcode    = ir[DATA_WIDTH-1 -: 4];
    assign operand   = ir[ADDR_WIDTH-1:0];
    assign mem_op    = (opcode == OP_LDA) || (opcode == OP_STO) ||
                       (opcode == OP_ADD) || (opcode == OP_SUB);
    assign is_store  = (opcode == OP_STO);
    assign is_sub    = (opcode == OP_SUB);
    assign running   = (state != HALTED);
    assign writedata = acc;

    generate
        if (DATA_WIDTH - 4 > ADDR_WIDTH) begin : g_unused_ir
            logic unused_ir_bits;
            assign unused_ir_bits = ^ir[DATA_WIDTH-5:ADDR_WIDTH];
        end
    endgenerate

    // Subtraction is acc + ~b + 1 so one adder serves both ADD and SUB.
    assign addend = is_sub ? ~readdata : readdata;
    assign sum    = acc + addend + DATA_WIDTH'(is_sub);

`ifdef CPU_MU0_PARAM_SATURATE_EN
    logic overflow;
    assign overflow   = (acc[DATA_WIDTH-1] == addend[DATA_WIDTH-1]) &&
                        (sum[DATA_WIDTH-1] != acc[DATA_WIDTH-1]);
    assign alu_result = !overflow         ? sum :
                        acc[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                            {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
    assign alu_result = sum;
`endif

    always_comb begin
        state_next = state;
        address    = pc;
        read       = 1'b0;
        write      = 1'b0;
        exec_done  = 1'b0;
        case (state)
            FETCH: begin
                read = 1'b1;
                if (!waitrequest) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                address = operand;
                if (mem_op) begin
                    read      = !is_store;
                    write     = is_store;
                    exec_done = !waitrequest;
                end else begin
                    exec_done = 1'b1;
                end
                if (exec_done) begin
                    state_next = (opcode == OP_STP) ? HALTED : FETCH;
                end
            end
            default: ;
        endcase
        // Reset abandons any in-flight access in the very cycle it is seen.
        if (rst) begin
            read  = 1'b0;
            write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_VECTOR;
            acc       <= '0;
            ir        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_next;
            out_valid <= 1'b0;
            if (state == FETCH && !waitrequest) begin
                ir <= readdata;
            end
            if (exec_done) begin
                pc <= pc + ADDR_WIDTH'(1);
                case (opcode)
                    OP_LDA: acc <= readdata;
                    OP_ADD: acc <= alu_result;
                    OP_SUB: acc <= alu_result;
                    OP_JMP: pc  <= operand;
                    OP_JGE: if (!acc[DATA_WIDTH-1]) pc <= operand;
                    OP_JNE: if (acc != '0) pc <= operand;
                    OP_OUT: begin
                        out_valid <= 1'b1;
                        out_data  <= acc;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mu0_param.sv
`default_nettype none
// Testbench for cpu_mu0_param: directed and random programs checked against an
// instruction-level interpreter; a second 32/8-bit instance checks PC wrap.
module tb_cpu_mu0_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: 16/12 bits, reset vector 0x100
    logic        rst = 1'b1;
    logic        running, read, write, waitrequest, out_valid;
    logic [11:0] address;
    logic [15:0] writedata, readdata, out_data;

    // Second instance: 32/8 bits
    logic        rst2 = 1'b1;
    logic        running2, read2, write2, out_valid2;
    logic        waitrequest2 = 1'b0;
    logic [7:0]  address2;
    logic [31:0] writedata2, readdata2, out_data2;

    cpu_mu0_param #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .RESET_VECTOR(12'h100)) dut (
        .clk(clk), .rst(rst), .running(running), .address(address),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .out_valid(out_valid), .out_data(out_data)
    );

    cpu_mu0_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_VECTOR(8'h00)) dut2 (
        .clk(clk), .rst(rst2), .running(running2), .address(address2),
        .read(read2), .write(write2), .writedata(writedata2), .readdata(readdata2),
        .waitrequest(waitrequest2), .out_valid(out_valid2), .out_data(out_data2)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory with a fixed number of stall cycles per request
    logic [15:0] mem  [4096];
    logic [31:0] mem2 [256];
    int          stall_len = 0;
    int          stall_cnt = 0;

    assign readdata    = mem[address];
    assign readdata2   = mem2[address2];
    assign waitrequest = (read | write) && (stall_cnt < stall_len);

    always @(posedge clk) begin
        if (write && !waitrequest) mem[address] = writedata;
        if (!(read | write) || !waitrequest) stall_cnt <= 0;
        else                                 stall_cnt <= stall_cnt + 1;
    end

    // Bus monitor: request stability during stalls, exclusivity, OUT capture
    logic [15:0] outq[$];
    logic        p_rq = 1'b0, p_rst = 1'b1, p_rd = 1'b0, p_wr = 1'b0;
    logic [11:0] p_addr = '0;
    logic [15:0] p_wd = '0;

    always @(negedge clk) begin
        #2;
        if (!rst && !p_rst && p_rq) begin
            chk("stall_address", address, p_addr);
            chk("stall_read", read, p_rd);
            chk("stall_write", write, p_wr);
            chk("stall_writedata", writedata, p_wd);
        end
        chk("rd_wr_exclusive", read & write, 1'b0);
        if (out_valid) outq.push_back(out_data);
        p_rq   = waitrequest && (read | write);
        p_rst  = rst;
        p_rd   = read;
        p_wr   = write;
        p_addr = address;
        p_wd   = writedata;
    end

    // Instruction-level reference interpreter
    logic [15:0] mm [4096];
    logic [15:0] exp_out[$];

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] s);
        return {op, s};
    endfunction

    function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b, input bit sub);
        int r;
        r = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
`ifdef CPU_MU0_PARAM_SATURATE_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    task automatic model(input logic [11:0] start, output int instrs, output int reqs);
        logic [11:0] pc;
        logic [15:0] acc, ir;
        logic [3:0]  op;
        logic [11:0] s;
        bit          halt;
        pc = start; acc = '0; instrs = 0; reqs = 0; halt = 0;
        exp_out.delete();
        while (!halt && instrs < 1000) begin
            ir = mm[pc]; op = ir[15:12]; s = ir[11:0];
            instrs++; reqs++;
            pc = pc + 12'd1;
            case (op)
                4'd0: begin acc = mm[s]; reqs++; end
                4'd1: begin mm[s] = acc; reqs++; end
                4'd2: begin acc = alu(acc, mm[s], 1'b0); reqs++; end
                4'd3: begin acc = alu(acc, mm[s], 1'b1); reqs++; end
                4'd4: pc = s;
                4'd5: if ($signed(acc) >= 0) pc = s;
                4'd6: if (acc != 0) pc = s;
                4'd7: halt = 1;
                4'd8: exp_out.push_back(acc);
                default: ;
            endcase
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = '0;
    endtask

    // Reset, release, count cycles until running falls (entered at a negedge)
    task automatic run(input int s, input int limit, output int cyc);
        stall_len = s;
        rst = 1'b1;
        outq.delete();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (running && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        chk("run_halted", running, 1'b0);
    endtask

    task automatic run_and_check(input string tag, input int s);
        int instrs, reqs, cyc;
        mm = mem;
        model(12'h100, instrs, reqs);
        run(s, 3000, cyc);
        chk({tag, "_cycles"}, cyc, 2 * instrs + s * reqs);
        chk({tag, "_out_count"}, outq.size(), exp_out.size());
        foreach (exp_out[i])
            chk($sformatf("%s_out%0d", tag, i), (i < outq.size()) ? outq[i] : 16'hxxxx, exp_out[i]);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_mem%0d", tag, i), mem[12'h200 + i], mm[12'h200 + i]);
    endtask

    initial begin
        int          n, k, cyc;
        logic [11:0] a, tgt;

        clear_mem();
        for (int i = 0; i < 256; i++) mem2[i] = 32'h9000_0000;
        repeat (2) @(negedge clk);

        chk("reset_running", running, 1'b1);
        chk("reset_read", read, 1'b0);
        chk("reset_write", write, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 16'h0000);
        chk("reset_acc", writedata, 16'h0000);

        // Basic program without and with stalls
        mem[12'h100] = ins(4'd0, 12'h10A);
        mem[12'h101] = ins(4'd2, 12'h10B);
        mem[12'h102] = ins(4'd8, 12'h000);
        mem[12'h103] = ins(4'd7, 12'h000);
        mem[12'h10A] = 16'd5;
        mem[12'h10B] = 16'd7;
        run(0, 200, cyc);
        chk("basic_cycles", cyc, 8);
        chk("basic_out_count", outq.size(), 1);
        chk("basic_out_data", (outq.size() > 0) ? outq[0] : 16'hxxxx, 16'd12);
        run(3, 200, cyc);
        chk("stall_cycles", cyc, 8 + 6 * 3);
        chk("stall_out_data", (outq.size() > 0) ? outq[0] : 16'hxxxx, 16'd12);
        run_and_check("basic_model", 2);

        // Branches
        clear_mem();
        mem[12'h200] = 16'hFFFF;
        mem[12'h201] = 16'h0000;
        mem[12'h100] = ins(4'd0, 12'h200);
        mem[12'h101] = ins(4'd5, 12'h120);
        mem[12'h102] = ins(4'd8, 12'h000);
        mem[12'h103] = ins(4'd6, 12'h130);
        mem[12'h104] = ins(4'd7, 12'h000);
        mem[12'h120] = ins(4'd8, 12'h000);
        mem[12'h121] = ins(4'd7, 12'h000);
        mem[12'h130] = ins(4'd0, 12'h201);
        mem[12'h131] = ins(4'd5, 12'h140);
        mem[12'h132] = ins(4'd7, 12'h000);
        mem[12'h140] = ins(4'd8, 12'h000);
        mem[12'h141] = ins(4'd7, 12'h000);
        run_and_check("branch", 1);
        chk("branch_jge_fallthrough", (outq.size() > 0) ? outq[0] : 16'hxxxx, 16'hFFFF);
        chk("branch_jge_taken", (outq.size() > 1) ? outq[1] : 16'hxxxx, 16'h0000);

        // Overflow at both signed limits
        clear_mem();
        mem[12'h200] = 16'h7FFF;
        mem[12'h201] = 16'h0001;
        mem[12'h202] = 16'h8000;
        mem[12'h100] = ins(4'd0, 12'h200);
        mem[12'h101] = ins(4'd2, 12'h201);
        mem[12'h102] = ins(4'd8, 12'h000);
        mem[12'h103] = ins(4'd0, 12'h202);
        mem[12'h104] = ins(4'd3, 12'h201);
        mem[12'h105] = ins(4'd8, 12'h000);
        mem[12'h106] = ins(4'd7, 12'h000);
        run_and_check("overflow", 0);
`ifdef CPU_MU0_PARAM_SATURATE_EN
        chk("overflow_add", (outq.size() > 0) ? outq[0] : 16'hxxxx, 16'h7FFF);
        chk("overflow_sub", (outq.size() > 1) ? outq[1] : 16'hxxxx, 16'h8000);
`else
        chk("overflow_add", (outq.size() > 0) ? outq[0] : 16'hxxxx, 16'h8000);
        chk("overflow_sub", (outq.size() > 1) ? outq[1] : 16'hxxxx, 16'h7FFF);
`endif

        // Random straight-line programs with forward skips
        for (int t = 0; t < 20; t++) begin
            clear_mem();
            for (int i = 0; i < 8; i++) mem[12'h200 + i] = 16'($urandom);
            n = $urandom_range(4, 24);
            for (int i = 0; i < n; i++) begin
                k   = $urandom_range(0, 8);
                a   = 12'h200 + 12'($urandom_range(0, 7));
                tgt = 12'h100 + 12'(i + 2);
                case (k)
                    0: mem[12'h100 + i] = ins(4'd0, a);
                    1: mem[12'h100 + i] = ins(4'd1, a);
                    2: mem[12'h100 + i] = ins(4'd2, a);
                    3: mem[12'h100 + i] = ins(4'd3, a);
                    4: mem[12'h100 + i] = ins(4'd8, a);
                    5: mem[12'h100 + i] = ins(4'($urandom_range(9, 15)), a);
                    6: mem[12'h100 + i] = ins(4'd4, tgt);
                    7: mem[12'h100 + i] = ins(4'd5, tgt);
                    default: mem[12'h100 + i] = ins(4'd6, tgt);
                endcase
            end
            mem[12'h100 + n]     = ins(4'd7, 12'h000);
            mem[12'h100 + n + 1] = ins(4'd7, 12'h000);
            run_and_check($sformatf("rand%0d", t), $urandom_range(0, 2));
        end

        // Reset during a stalled STO
        clear_mem();
        mem[12'h200] = 16'h1234;
        mem[12'h201] = 16'h5555;
        mem[12'h100] = ins(4'd0, 12'h200);
        mem[12'h101] = ins(4'd1, 12'h201);
        mem[12'h102] = ins(4'd7, 12'h000);
        stall_len = 5;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!write && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rststall_write_seen", write, 1'b1);
        chk("rststall_stalled", waitrequest, 1'b1);
        rst = 1'b1;
        #1;
        chk("rststall_write_drop", write, 1'b0);
        chk("rststall_read_drop", read, 1'b0);
        stall_len = 0;
        @(negedge clk);
        chk("rststall_acc_cleared", writedata, 16'h0000);
        chk("rststall_mem_unchanged", mem[12'h201], 16'h5555);
        rst = 1'b0;
        #1;
        chk("rststall_refetch_addr", address, 12'h100);
        chk("rststall_refetch_read", read, 1'b1);
        n = 0;
        while (running && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rststall_rerun_halted", running, 1'b0);
        chk("rststall_rerun_store", mem[12'h201], 16'h1234);

        // 32/8-bit instance: JMP 0xFF then NOP wraps PC to 0x00
        mem2[8'h00] = 32'h4000_00FF;
        mem2[8'hFF] = 32'h9000_0000;
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("w32_fetch0_addr", address2, 8'h00);
        chk("w32_fetch0_read", read2, 1'b1);
        @(negedge clk);
        chk("w32_exec_jmp_read", read2, 1'b0);
        @(negedge clk);
        chk("w32_fetchff_addr", address2, 8'hFF);
        chk("w32_fetchff_read", read2, 1'b1);
        @(negedge clk);
        chk("w32_exec_nop_read", read2, 1'b0);
        @(negedge clk);
        chk("w32_wrap_addr", address2, 8'h00);
        chk("w32_wrap_read", read2, 1'b1);
        chk("w32_running", running2, 1'b1);
        rst2 = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_mu0_param.md
# cpu_mu0_param

Parametrised multi-cycle MU0 accumulator CPU, the next generation of the lab MU0 core. Generalises data and address widths and adds a waitrequest-stalled memory bus, so the core works with slow or arbitrated memories. It also adds a registered OUT port in place of simulation-only printing. It sits between the testbench/top level and a single shared instruction+data memory.

## Interface
- `DATA_WIDTH`, default 16: accumulator and memory word width. Must be at least `ADDR_WIDTH+4`.
- `ADDR_WIDTH`, default 12: word address width and operand field width.
- `RESET_VECTOR`, default 0: PC value loaded on reset.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `running`, output, 1: high from reset until STP.
- `address`, output, `ADDR_WIDTH`: memory word address.
- `read`, output, 1: read request.
- `write`, output, 1: write request.
- `writedata`, output, `DATA_WIDTH`: always equals ACC.
- `readdata`, input, `DATA_WIDTH`: valid in any cycle where `read=1` and `waitrequest=0`.
- `waitrequest`, input, 1: memory stall; the request must be held while it is high.
- `out_valid`, output, 1: one-cycle pulse per retired OUT.
- `out_data`, output, `DATA_WIDTH`: ACC captured by the last OUT.

## Operation
- Instruction word format:
  - Opcode is `instr[DATA_WIDTH-1 -: 4]`.
  - Operand S is `instr[ADDR_WIDTH-1:0]`.
  - Any bits in between are ignored.
- Opcodes:
  - LDA=0: ACC:=mem[S].
  - STO=1: mem[S]:=ACC.
  - ADD=2: ACC:=ACC+mem[S].
  - SUB=3: ACC:=ACC−mem[S].
  - JMP=4: PC:=S.
  - JGE=5: if signed ACC≥0 then PC:=S.
  - JNE=6: if ACC≠0 then PC:=S.
  - STP=7: halt.
  - OUT=8: out_data:=ACC and pulse out_valid.
  - Opcodes 9–15 are NOPs.
- Non-taken branches and all non-jump instructions set PC:=PC+1, wrapping modulo 2^ADDR_WIDTH.
- Arithmetic is two's complement at `DATA_WIDTH` and wraps by default (see Configuration).
- States:
  - HALTED: power-on state. `running=0`; no bus activity. Only `rst` leaves it.
  - FETCH: `address=PC`, `read=1`. When `waitrequest=0`: latch `readdata` into IR and go to EXEC. Otherwise stay.
  - EXEC, for LDA/ADD/SUB: `address=S`, `read=1`.
  - EXEC, for STO: `address=S`, `write=1`.
  - EXEC, memory instructions complete in the cycle where `waitrequest=0`: update ACC/PC, then go to FETCH.
  - EXEC, for all other opcodes: no request is issued and `waitrequest` is ignored. They complete in one cycle and go to FETCH; STP goes to HALTED with `running<=0`.
- `read` and `write` are never both high.
- `address`, `read`, `write` and `writedata` are stable throughout a stalled request.
- Reset:
  - Sets `state=FETCH`, `PC=RESET_VECTOR`, `ACC=0`, `IR=0`, `running=1`, `out_valid=0`, `out_data=0`.
  - `read` and `write` are forced to 0 in any cycle where `rst` is high.
  - Reset mid-request, including while stalled, abandons the access immediately.
- Power-on value before any reset: HALTED, `running=0`.

## Timing
- With `waitrequest` tied low, every instruction takes exactly 2 cycles (FETCH, EXEC).
- Each stall cycle adds one cycle to the phase in which it occurs.
- The first fetch request appears in the cycle after `rst` deasserts.
- `out_valid` is registered: high for exactly the one cycle after the OUT EXEC edge, and `out_data` updates on the same edge.
- `running` falls on the clock edge that completes STP's EXEC.
- ACC and PC updates become visible the cycle after EXEC completes. A STO that immediately follows a LDA writes the new ACC value.

## Configuration
- `CPU_MU0_PARAM_SATURATE_EN`:
  - Defined: ADD and SUB saturate at signed `DATA_WIDTH` limits, e.g. 0x7FFF+1=0x7FFF and 0x8000−1=0x8000 at width 16.
  - Undefined: ADD and SUB wrap modulo 2^DATA_WIDTH.
  - All other behaviour is identical in both builds.

## Test plan
- Basic program, `waitrequest=0`, mem[0..3]={LDA 10, ADD 11, OUT, STP}, mem[10]=5, mem[11]=7 → `out_valid` pulses once with `out_data`=12. `running` falls exactly 8 cycles after reset release.
- Stalls: same program with `waitrequest` high for 3 cycles on every request → same result, completing after 8+6×3 cycles. `address`/`read` are stable during stalls.
- Branches: ACC=0xFFFF (−1) with JGE 20 → falls through to PC+1. JNE 20 → PC=20. ACC=0 with JGE 20 → taken.
- Overflow: mem holds 0x7FFF and 1, program LDA, ADD, OUT → `out_data`=0x8000 without the macro and 0x7FFF with `CPU_MU0_PARAM_SATURATE_EN`.
- Reset mid-stall: assert `rst` during a stalled STO → `write` drops in the reset cycle and memory is unchanged. Execution restarts at `RESET_VECTOR`=0x100 with ACC=0.
- Parametrisation: `DATA_WIDTH=32`, `ADDR_WIDTH=8`, JMP 0xFF followed by a NOP at 0xFF → PC wraps to 0x00.
